// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the HI/LO multiply/divide sequencer:
//             operation encodings, controller state type and a helper that
//             sizes the latency down-counter.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Counter must hold max(MUL_CYCLES, DIV_CYCLES)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int mul_cycles, input int div_cycles);
        int m;
        int w;
        m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Multicycle sequencer for the HI/LO multiply/divide datapath.
//             Accepts one request at a time, latches its operands, waits the
//             modelled iteration latency, then pulses a single write enable.
//             While busy it stalls the main FSM on HI/LO requests and reads.
//  Ports    : clk, rst_n (async active-low)
//             start, op[2:0], da[31:0], db[31:0] - request from main FSM
//             rd_req                              - mfhi/mflo read this cycle
//             md_we, md_op, md_da, md_db          - to muldiv_module
//             busy, stall, done                   - status to main FSM
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        rd_req,
    output logic        md_we,
    output logic [2:0]  md_op,
    output logic [31:0] md_da,
    output logic [31:0] md_db,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int                c_cnt_w    = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                w_accept;
    logic                w_md_we;
    logic [2:0]          r_md_op;
    logic [31:0]         r_md_da;
    logic [31:0]         r_md_db;

    // ------------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_md_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_accept    = 1'b1;
                            w_state_nxt = WAIT;
                            w_cnt_nxt   = c_mul_load;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_accept    = 1'b1;
                            w_state_nxt = WAIT;
                            w_cnt_nxt   = c_div_load;
                        end
                        // Register moves need no iteration time.
                        OP_MTHI, OP_MTLO: begin
                            w_accept    = 1'b1;
                            w_state_nxt = COMMIT;
                        end
                        // Reserved encodings are silently dropped.
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            COMMIT: begin
                w_md_we     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and operand latches
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_md_op <= '0;
            r_md_da <= '0;
            r_md_db <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_md_op <= op;
                r_md_da <= da;
                r_md_db <= db;
            end
        end
    end

    assign md_op = r_md_op;
    assign md_da = r_md_da;
    assign md_db = r_md_db;
    assign md_we = w_md_we;
    assign done  = w_md_we;
    assign busy  = (r_state != IDLE);
    // Combinational so the main FSM holds in the same cycle it asks.
    assign stall = busy & (start | rd_req);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl. A timeline model predicts
//             busy/stall/write timing from operation latencies, and a HI/LO
//             register model stands in for the datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [2:0]  op     = 3'd0;
    logic [31:0] da     = 32'd0;
    logic [31:0] db     = 32'd0;
    logic        rd_req = 1'b0;
    logic        md_we;
    logic [2:0]  md_op;
    logic [31:0] md_da;
    logic [31:0] md_db;
    logic        busy;
    logic        stall;
    logic        done;

    muldiv_ctrl #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .da     (da),
        .db     (db),
        .rd_req (rd_req),
        .md_we  (md_we),
        .md_op  (md_op),
        .md_da  (md_da),
        .md_db  (md_db),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Timeline model: controller is busy for cycles < free_at, writes at we_at.
    longint      cyc     = 0;
    longint      free_at = 0;
    longint      we_at   = -1;
    logic        exp_b;
    logic [3:0]  exp_status, obs_status;
    logic [66:0] exp_md, obs_md;
    logic [2:0]  exp_op = 3'd0;
    logic [31:0] exp_da = 32'd0, exp_db = 32'd0;
    logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
    logic [31:0] dp_hi  = 32'd0, dp_lo  = 32'd0;
    logic [31:0] obs_hi;

    function automatic int lat(input logic [2:0] o);
        if (o < 3'd2)      return MUL_CYCLES + 1;
        else if (o < 3'd4) return DIV_CYCLES + 1;
        else               return 1;
    endfunction

    // MIPS HI/LO semantics: returns {HI, LO}.
    function automatic logic [63:0] hilo(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
        logic signed [63:0] xa, xb;
        logic        [63:0] ua, ub;
        logic signed [31:0] sa, sb;
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = a;
        sb = b;
        case (o)
            3'd0: return xa * xb;
            3'd1: return ua * ub;
            3'd2: return (b == 0) ? {hi, lo} : {32'(sa % sb), 32'(sa / sb)};
            3'd3: return (b == 0) ? {hi, lo} : {a % b, a / b};
            3'd4: return {a, lo};
            3'd5: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Datapath stand-in: HI/LO update at the end of the write-enable cycle.
    always @(posedge clk) begin
        if (md_we) {dp_hi, dp_lo} <= hilo(md_op, md_da, md_db, dp_hi, dp_lo);
    end

    // Drives one cycle (entered just after a negedge), samples, advances model.
    task automatic run_cycle(input logic s, input logic [2:0] o, input logic [31:0] a_in,
                             input logic [31:0] b_in, input logic r);
        logic ew;
        start = s; op = o; da = a_in; db = b_in; rd_req = r;
        #1;
        obs_status = {busy, stall, md_we, done};
        obs_md     = {md_op, md_da, md_db};
        obs_hi     = dp_hi;
        exp_b      = (cyc < free_at);
        ew         = (cyc == we_at);
        exp_status = {exp_b, exp_b & (s | r), ew, ew};
        exp_md     = {exp_op, exp_da, exp_db};
        if (!exp_b && s && o <= 3'd5) begin
            free_at = cyc + 1 + lat(o);
            we_at   = cyc + lat(o);
            exp_op  = o;
            exp_da  = a_in;
            exp_db  = b_in;
        end
        @(posedge clk);
        if (ew) {exp_hi, exp_lo} = hilo(exp_op, exp_da, exp_db, exp_hi, exp_lo);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        while (cyc < free_at) run_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        start = 1'b1; rd_req = 1'b1; op = 3'd2;
        #1;
        n_total++;
        if ({busy, stall, md_we, done} !== 4'b0000)
            $display("FAIL reset_status got %b want 0000", {busy, stall, md_we, done});
        else n_pass++;
        n_total++;
        if ({md_op, md_da, md_db} !== 67'd0)
            $display("FAIL reset_md got %h want 0", {md_op, md_da, md_db});
        else n_pass++;
        repeat (2) @(negedge clk);
        start = 1'b0; rd_req = 1'b0;
        rst_n = 1'b1;
        cyc = 0; free_at = 0; we_at = -1;
    endtask

    task automatic test_mult();
        int busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle(k == 0, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
            busy_cnt += obs_status[3];
            n_total++;
            if (obs_status !== exp_status || obs_status[1] !== (k == 5))
                $display("FAIL mult_status k=%0d got %b want %b", k, obs_status, exp_status);
            else n_pass++;
        end
        n_total++;
        if (busy_cnt != 5) $display("FAIL mult_busy_len got %0d want 5", busy_cnt);
        else n_pass++;
        n_total++;
        if ({dp_hi, dp_lo} !== 64'hFFFF_FFFF_FFFF_FFFA)
            $display("FAIL mult_hilo got %h want FFFFFFFFFFFFFFFA", {dp_hi, dp_lo});
        else n_pass++;
    endtask

    task automatic test_divu_stall();
        for (int k = 0; k < 36; k++) begin
            run_cycle(k == 0, 3'd3, 32'd100, 32'd7, k >= 1);
            n_total++;
            if (obs_status !== exp_status || obs_status[2] !== (k >= 1 && k <= 33) ||
                obs_status[1] !== (k == 33))
                $display("FAIL divu_status k=%0d got %b want %b", k, obs_status, exp_status);
            else n_pass++;
        end
        n_total++;
        if (dp_lo !== 32'd14 || dp_hi !== 32'd2)
            $display("FAIL divu_hilo got hi=%0d lo=%0d want hi=2 lo=14", dp_hi, dp_lo);
        else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) run_cycle(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
            else        run_cycle(k <= 2, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
            n_total++;
            if (obs_status !== exp_status || obs_status[1] !== (k == 1 || k == 3) ||
                obs_status[2] !== (k == 1))
                $display("FAIL mtx_status k=%0d got %b want %b", k, obs_status, exp_status);
            else n_pass++;
            n_total++;
            if (obs_md !== exp_md)
                $display("FAIL mtx_md k=%0d got %h want %h", k, obs_md, exp_md);
            else n_pass++;
        end
        n_total++;
        if (dp_hi !== 32'hDEAD_BEEF || dp_lo !== 32'h1234_5678)
            $display("FAIL mtx_hilo got %h:%h want deadbeef:12345678", dp_hi, dp_lo);
        else n_pass++;
    endtask

    task automatic test_reserved();
        for (int k = 0; k < 6; k++) begin
            run_cycle(k < 2, (k == 0) ? 3'd7 : 3'd6, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
            n_total++;
            if (obs_status !== 4'b0000 || obs_md !== exp_md)
                $display("FAIL reserved k=%0d got %b/%h want 0000/%h", k, obs_status, obs_md, exp_md);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] hi0, lo0;
        hi0 = dp_hi; lo0 = dp_lo;
        for (int k = 0; k < 10; k++) run_cycle(k == 0, 3'd2, 32'd1000, 32'd3, 1'b0);
        start = 1'b1; rd_req = 1'b1; op = 3'd0;
        #1;
        n_total++;
        if ({busy, stall} !== 2'b11) $display("FAIL rst_pre got %b want 11", {busy, stall});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, stall, md_we, done, md_op} !== 7'd0)
            $display("FAIL rst_async got %b want 0", {busy, stall, md_we, done, md_op});
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk); cyc++;
            #1;
            n_total++;
            if ({busy, md_we} !== 2'b00) $display("FAIL rst_hold k=%0d got %b want 00", k, {busy, md_we});
            else n_pass++;
        end
        start = 1'b0; rd_req = 1'b0;
        rst_n = 1'b1;
        free_at = cyc; we_at = -1;
        exp_op = 3'd0; exp_da = 32'd0; exp_db = 32'd0;
        n_total++;
        if (dp_hi !== hi0 || dp_lo !== lo0)
            $display("FAIL rst_hilo got %h:%h want %h:%h", dp_hi, dp_lo, hi0, lo0);
        else n_pass++;
        for (int k = 0; k < 7; k++) begin
            run_cycle(k == 0, 3'd0, 32'd7, 32'd6, 1'b0);
            n_total++;
            if (obs_status !== exp_status || obs_md !== exp_md)
                $display("FAIL rst_mult k=%0d got %b/%h want %b/%h", k, obs_status, obs_md, exp_status, exp_md);
            else n_pass++;
        end
        n_total++;
        if (dp_hi !== 32'd0 || dp_lo !== 32'd42)
            $display("FAIL rst_mult_hilo got %h:%h want 0:42", dp_hi, dp_lo);
        else n_pass++;
    endtask

    task automatic test_start_rd_idle();
        run_cycle(1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
        run_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        run_cycle(1'b1, 3'd0, 32'd3, 32'd4, 1'b1);
        n_total++;
        if (obs_status[2] !== 1'b0 || obs_hi !== 32'd5)
            $display("FAIL idle_rd got stall=%b hi=%0d want stall=0 hi=5", obs_status[2], obs_hi);
        else n_pass++;
        run_cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_total++;
        if (obs_status[3] !== 1'b1 || obs_md !== {3'd0, 32'd3, 32'd4})
            $display("FAIL idle_accept got busy=%b md=%h want busy=1", obs_status[3], obs_md);
        else n_pass++;
        drain();
        n_total++;
        if (dp_hi !== 32'd0 || dp_lo !== 32'd12)
            $display("FAIL idle_hilo got %h:%h want 0:12", dp_hi, dp_lo);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        pend = 1'b0;
        logic [2:0]  po = 3'd0;
        logic [31:0] pa = 32'd0, pb = 32'd0;
        logic        r;
        for (int k = 0; k < 400; k++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                po   = 3'($urandom_range(0, 7));
                pa   = $urandom;
                pb   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                if (po == 3'd2 || po == 3'd3) begin
                    if (pb == 32'd0 || pb == 32'hFFFF_FFFF) pb = 32'd9;
                end
            end
            r = ($urandom_range(0, 3) == 0);
            run_cycle(pend, po, pa, pb, r);
            if (pend && !exp_b) pend = 1'b0;
            n_total++;
            if (obs_status !== exp_status || obs_md !== exp_md)
                $display("FAIL random k=%0d got %b/%h want %b/%h", k, obs_status, obs_md, exp_status, exp_md);
            else n_pass++;
        end
        drain();
        n_total++;
        if (dp_hi !== exp_hi || dp_lo !== exp_lo)
            $display("FAIL random_hilo got %h:%h want %h:%h", dp_hi, dp_lo, exp_hi, exp_lo);
        else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult();
        drain();
        test_divu_stall();
        drain();
        test_mthi_mtlo();
        drain();
        test_reserved();
        test_reset_mid_op();
        drain();
        test_start_rd_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
